alu_seq_unit: RTL and testbench
===============================

ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and result width.
REQ-002 The block SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1: op, a and b are valid.
REQ-005 The block SHALL have port in_ready, output, 1: the unit accepts a request this cycle.
REQ-006 The block SHALL have port op, input, 4: ALU operation code driven by ALUControl.
REQ-007 The block SHALL have ports a and b, input, XLEN each: operand A and operand B; b[4:0] is the shift amount.
REQ-008 The block SHALL have port out_valid, output, 1: result, zero and illegal are valid.
REQ-009 The block SHALL have port out_ready, input, 1: the consumer takes the result this cycle.
REQ-010 The block SHALL have port result, output, XLEN: operation result.
REQ-011 The block SHALL have ports zero and illegal, output, 1 each: zero means result == 0; illegal means op was unassigned.
REQ-012 The block SHALL have port busy, output, 1: the state is not IDLE.

Function
REQ-013 A request SHALL be accepted on a rising edge when in_valid && in_ready; op, a and b are captured then.
REQ-014 The op codes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SLT (signed), 1000 SRA, 1001 SLTU.
REQ-015 For op codes 1010-1111, result SHALL be 0, illegal SHALL be 1, and latency SHALL be that of a non-shift op.
REQ-016 ADD and SUB SHALL wrap modulo 2^XLEN; SLT and SLTU SHALL return 1 or 0 zero-extended.
REQ-017 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-018 A non-shift op accepted at edge N SHALL enter DONE with out_valid=1 after edge N, i.e. a one-cycle latency.
REQ-019 For a shift op with shamt=0, the unit SHALL go directly to DONE with result=a, a one-cycle latency.
REQ-020 For a shift op with shamt>0, the unit SHALL enter SHIFT and shift the working register 1 bit per cycle; SRA replicates the sign bit.
REQ-021 A shift op SHALL reach DONE exactly shamt edges after entering SHIFT, giving a total latency of shamt+1 cycles.
REQ-022 In DONE, result, zero, illegal and out_valid SHALL hold stable until out_valid && out_ready.
REQ-023 in_ready SHALL equal (state==IDLE) || (state==DONE && out_ready).
REQ-024 A result handshake coinciding with a new acceptance SHALL start the new op with no bubble; otherwise a handshake SHALL return the FSM to IDLE.
REQ-025 in_valid SHALL be ignored in SHIFT, and in DONE while out_ready is low.
REQ-026 Outputs SHALL be registered; combinational paths SHALL be limited to in_ready depending on out_ready.

Reset
REQ-027 When rst_n=0 at a rising edge, the state SHALL go to IDLE and out_valid, result, zero, illegal and busy SHALL be 0.
REQ-028 Reset during SHIFT or DONE SHALL discard the pending op; no out_valid SHALL follow it.
REQ-029 in_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-030 Op codes, the state enum and XLEN default SHALL live in a shared package, alu_pkg, which ALUControl also uses.
REQ-031 The single-cycle operations (AND, OR, ADD, XOR, SUB, SLT, SLTU) SHALL be in one combinational sub-module, alu_comb; alu_seq_unit holds the FSM, the shift register, the shift counter and the output registers.

Verification
REQ-032 The bench SHALL cover: ADD with a=0x7FFFFFFF, b=1 -> after 1 cycle result=0x80000000, zero=0; SUB with a=b=5 -> result=0, zero=1.
REQ-033 The bench SHALL cover: SRA with a=0x80000000, b=4 -> out_valid 5 cycles after accept, result=0xF8000000, busy=1 for 5 cycles.
REQ-034 The bench SHALL cover: SLL with b=0 and a=0x1234 -> 1-cycle latency, result=0x1234; op=1111 -> result=0, illegal=1.
REQ-035 The bench SHALL cover backpressure: out_ready=0 for 3 cycles -> result stable and in_ready=0; then out_ready=1 with in_valid=1 -> back-to-back acceptance.
REQ-036 The bench SHALL cover: rst_n=0 for one edge mid-SRL (b=20) -> IDLE next cycle, out_valid never asserted for that op.
REQ-037 The bench SHALL sweep all 16 op codes with random operands against a reference model, checking SLT(-1,1)=1 and SLTU(-1,1)=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operand width default, op codes,
// FSM state encodings and the shift-op classifier.
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU operations. Shift op codes yield zero here because the
// sequencer iterates them; unassigned op codes flag illegal with a zero result.
module alu_comb
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] result_o,
    output logic            illegal_o
);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        result_o  = '0;
        illegal_o = 1'b0;
        case (op_i)
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_ADD:  result_o = a_i + b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_SUB:  result_o = a_i - b_i;
            OP_SLT:  result_o[0] = $signed(a_i) < $signed(b_i);
            OP_SLTU: result_o[0] = a_i < b_i;
            OP_SLL, OP_SRL, OP_SRA: result_o = '0;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_seq_unit.sv
// Sequential ALU: single-cycle ops complete in one cycle, shifts iterate one bit
// per cycle, and the registered result is held until the consumer takes it.
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal,
    output logic            busy
);

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] work_q, work_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [3:0]      op_q, op_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;
    logic            out_valid_q, out_valid_d;

    logic [XLEN-1:0] comb_result;
    logic            comb_illegal;
    logic [XLEN-1:0] quick_result;
    logic [XLEN-1:0] shift_step;
    logic            accept;

    alu_comb #(.XLEN(XLEN)) u_alu_comb (
        .op_i      (op),
        .a_i       (a),
        .b_i       (b),
        .result_o  (comb_result),
        .illegal_o (comb_illegal)
    );

    assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    // A zero-distance shift passes operand A straight through.
    assign quick_result = is_shift(op) ? a : comb_result;

    always_comb begin
        case (op_q)
            OP_SLL:  shift_step = work_q << 1;
            OP_SRL:  shift_step = work_q >> 1;
            default: shift_step = {work_q[XLEN-1], work_q[XLEN-1:1]};
        endcase
    end

    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        result_d    = result_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_SHIFT: begin
                work_d = shift_step;
                cnt_d  = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d     = ST_DONE;
                    result_d    = shift_step;
                    zero_d      = (shift_step == '0);
                    illegal_d   = 1'b0;
                    out_valid_d = 1'b1;
                end
            end
            ST_IDLE, ST_DONE: begin
                if ((state_q == ST_DONE) && out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
                if (accept) begin
                    op_d   = op;
                    work_d = a;
                    cnt_d  = b[4:0];
                    if (is_shift(op) && (b[4:0] != 5'd0)) begin
                        state_d     = ST_SHIFT;
                        out_valid_d = 1'b0;
                    end else begin
                        state_d     = ST_DONE;
                        result_d    = quick_result;
                        zero_d      = (quick_result == '0);
                        illegal_d   = comb_illegal;
                        out_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            work_q      <= '0;
            cnt_q       <= '0;
            op_q        <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit: a scoreboard of expected results fed on
// acceptance and drained on each output handshake, plus directed timing checks.
module tb_alu_seq_unit;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;
    logic            busy;

    typedef struct {
        logic [XLEN-1:0] res;
        logic            ill;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    alu_seq_unit #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
        exp_t e;
        e.ill = 1'b0;
        e.res = '0;
        case (o)
            4'd0: e.res = x & y;
            4'd1: e.res = x | y;
            4'd2: e.res = x + y;
            4'd3: e.res = x ^ y;
            4'd4: e.res = x << y[4:0];
            4'd5: e.res = x >> y[4:0];
            4'd6: e.res = x - y;
            4'd7: e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd8: e.res = $signed(x) >>> y[4:0];
            4'd9: e.res = (x < y) ? 32'd1 : 32'd0;
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    // Scoreboard drain: every handshake must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_result", result, e.res);
                check("sb_zero", zero, (e.res == '0));
                check("sb_illegal", illegal, e.ill);
            end
        end
    end

    // Drive one request; returns #1 after the accepting edge.
    task automatic send(input logic [3:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                        output int waited);
        waited   = 0;
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        #1;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
        end else begin
            @(posedge clk);
            sb.push_back(model(o, x, y));
        end
        #1;
        in_valid = 1'b0;
    endtask

    // Count negedges from the accepting edge until out_valid is seen.
    task automatic wait_valid(output int lat);
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        check("valid_seen", out_valid, 1);
    endtask

    task automatic run(input logic [3:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                       output int lat);
        int w;
        send(o, x, y, w);
        wait_valid(lat);
    endtask

    initial begin
        int lat;
        int w;
        int busy_cnt;
        int ov_seen;
        logic [XLEN-1:0] held;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = '0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_zero", zero, 0);
        check("rst_illegal", illegal, 0);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);

        run(4'b0010, 32'h7FFF_FFFF, 32'd1, lat);
        check("add_lat", lat, 1);
        check("add_result", result, 32'h8000_0000);
        check("add_zero", zero, 0);

        run(4'b0110, 32'd5, 32'd5, lat);
        check("sub_result", result, 0);
        check("sub_zero", zero, 1);

        // SRA by 4: four SHIFT cycles then DONE.
        send(4'b1000, 32'h8000_0000, 32'd4, w);
        busy_cnt = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (k < 5) check("sra_early_valid", out_valid, 0);
        end
        check("sra_valid_at_5", out_valid, 1);
        check("sra_result", result, 32'hF800_0000);
        @(negedge clk);
        check("sra_idle_after", busy, 0);
        check("sra_busy_cycles", busy_cnt, 5);

        run(4'b0100, 32'h0000_1234, 32'd0, lat);
        check("sll0_lat", lat, 1);
        check("sll0_result", result, 32'h1234);

        run(4'b1111, 32'hDEAD_BEEF, 32'h1234_5678, lat);
        check("illegal_lat", lat, 1);
        check("illegal_result", result, 0);
        check("illegal_flag", illegal, 1);

        // Backpressure, then release with a coinciding new request.
        @(posedge clk);
        #1 out_ready = 1'b0;
        run(4'b0001, 32'h00F0_0000, 32'h0000_000F, lat);
        held = result;
        check("bp_first_result", held, 32'h00F0_000F);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_valid_held", out_valid, 1);
            check("bp_result_held", result, held);
            check("bp_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(4'b0011, 32'hFFFF_0000, 32'h0F0F_0F0F, w);
        check("b2b_no_wait", w, 0);
        @(negedge clk);
        check("b2b_valid", out_valid, 1);
        check("b2b_result", result, 32'hF0F0_0F0F);
        @(negedge clk);

        // Reset mid-SRL discards the pending op.
        send(4'b0101, 32'hFFFF_FFFF, 32'd20, w);
        repeat (5) @(negedge clk);
        check("srl_busy_mid", busy, 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        sb.delete();
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_result", result, 0);
        check("mid_rst_in_ready", in_ready, 1);
        ov_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) ov_seen++;
        end
        check("mid_rst_no_valid", ov_seen, 0);

        // Sweep every op code with random operands.
        for (int o = 0; o < 16; o++) begin
            repeat (3) begin
                run(o[3:0], $urandom, $urandom, lat);
                @(negedge clk);
            end
        end

        run(4'b0111, 32'hFFFF_FFFF, 32'd1, lat);
        check("slt_neg1_1", result, 1);
        run(4'b1001, 32'hFFFF_FFFF, 32'd1, lat);
        check("sltu_neg1_1", result, 0);

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
